adc1_capture_packer: RTL and testbench

//  Receive side of the ADC readout path. It consumes the latency-aligned adc1 data-valid strobe and
//  the ADC sample bus on adc1_out_clk, and packs samples into 64-bit words for the host FIFO.

---
 rtl/adc1_capture_packer_pkg.sv | 32 +++
 rtl/adc1_capture_packer_if.sv | 29 ++
 rtl/adc1_capture_packer_sync_2ff.sv | 16 +
 rtl/adc1_capture_packer.sv | 122 ++++++++++++
 tb/tb_adc1_capture_packer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc1_capture_packer_pkg.sv
// adc1_capture_packer_pkg: readout constants, FSM encoding and header layout shared with the host-side unpacker.
package adc1_capture_packer_pkg;

    localparam int ADC_W  = 16;
    localparam int OUT_W  = 64;
    localparam int LANE_W = 16;
    localparam int LANES  = OUT_W / LANE_W;

    localparam logic [15:0] HDR_TAG = 16'hA5C3;

    // Header layout: [63:48] tag, [47:32] frame count, [31:16] reserved, [15:0] zero-extended row count
    localparam int HDR_TAG_LSB = 48;
    localparam int HDR_CNT_LSB = 32;
    localparam int HDR_ROW_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_CAP,
        S_DONE
    } state_t;

    function automatic logic [OUT_W-1:0] make_header(input logic [15:0] cnt, input logic [9:0] rows);
        logic [OUT_W-1:0] h;
        h = '0;
        h[HDR_TAG_LSB +: 16] = HDR_TAG;
        h[HDR_CNT_LSB +: 16] = cnt;
        h[HDR_ROW_LSB +: 16] = {6'b0, rows};
        return h;
    endfunction

endpackage

// File: rtl/adc1_capture_packer_if.sv
// adc1_capture_packer_if: sample input, frame control and FIFO write bundle of the ADC capture packer.
interface adc1_capture_packer_if;
    import adc1_capture_packer_pkg::*;

    logic             arm;
    logic [9:0]       num_row;
    logic [15:0]      samples_per_row;
    logic             adc_dat_valid;
    logic [ADC_W-1:0] adc_data;
    logic             fifo_full;
    logic [OUT_W-1:0] fifo_din;
    logic             fifo_wr_en;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    logic             overflow;
    logic             sample_err;

    modport master (
        output arm, num_row, samples_per_row, adc_dat_valid, adc_data, fifo_full,
        input  fifo_din, fifo_wr_en, busy, frame_done, frame_cnt, overflow, sample_err
    );

    modport slave (
        input  arm, num_row, samples_per_row, adc_dat_valid, adc_data, fifo_full,
        output fifo_din, fifo_wr_en, busy, frame_done, frame_cnt, overflow, sample_err
    );

endinterface

// File: rtl/adc1_capture_packer_sync_2ff.sv
// adc1_capture_packer_sync_2ff: two-flop synchroniser for a single quasi-static level.
module adc1_capture_packer_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk)
        sync_q <= rst ? 2'b00 : {sync_q[0], d_i};

    assign q_o = sync_q[1];

endmodule

// File: rtl/adc1_capture_packer.sv
// adc1_capture_packer: packs latency-aligned ADC samples into 64-bit FIFO words,
// framing each armed capture with a header word and flagging overflow/stray samples.
module adc1_capture_packer
    import adc1_capture_packer_pkg::*;
(
    input logic                  adc1_out_clk,
    input logic                  rst,
    adc1_capture_packer_if.slave bus
);

    logic                         arm_s;
    logic                         arm_s_d_q;
    state_t                       state_q;
    logic [1:0]                   lane_cnt_q;
    logic [15:0]                  sample_cnt_q;
    logic [9:0]                   row_cnt_q;
    logic [LANES-1:0][LANE_W-1:0] lanes_q;
    logic [LANES-1:0][LANE_W-1:0] lanes_d;
    logic [OUT_W-1:0]             fifo_din_q;
    logic                         fifo_wr_en_q;
    logic                         busy_q;
    logic                         frame_done_q;
    logic [15:0]                  frame_cnt_q;
    logic                         overflow_q;
    logic                         sample_err_q;

    logic arm_rise;
    logic accept;
    logic last_sample;
    logic last_row;
    logic emit;
    logic degenerate;

    adc1_capture_packer_sync_2ff u_arm_sync (
        .clk (adc1_out_clk),
        .rst (rst),
        .d_i (bus.arm),
        .q_o (arm_s)
    );

    always_comb begin
        lanes_d = lanes_q;
        lanes_d[lane_cnt_q] = LANE_W'(bus.adc_data);
    end

    assign arm_rise    = arm_s & ~arm_s_d_q;
    assign accept      = (state_q == S_CAP) && bus.adc_dat_valid;
    assign last_sample = sample_cnt_q == bus.samples_per_row - 16'd1;
    assign last_row    = row_cnt_q == bus.num_row - 10'd1;
    assign emit        = (lane_cnt_q == 2'(LANES - 1)) || last_sample;
    assign degenerate  = (bus.num_row == '0) || (bus.samples_per_row == '0);

    always_ff @(posedge adc1_out_clk) begin
        if (rst) begin
            arm_s_d_q    <= 1'b0;
            state_q      <= S_IDLE;
            lane_cnt_q   <= '0;
            sample_cnt_q <= '0;
            row_cnt_q    <= '0;
            lanes_q      <= '0;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            sample_err_q <= 1'b0;
        end else begin
            arm_s_d_q    <= arm_s;
            fifo_wr_en_q <= 1'b0;
            frame_done_q <= 1'b0;
            // The FIFO silently drops a word written while full; only the sticky flag records it.
            overflow_q   <= overflow_q | (fifo_wr_en_q & bus.fifo_full);
            sample_err_q <= sample_err_q | (bus.adc_dat_valid & (state_q != S_CAP));
            case (state_q)
                S_IDLE: begin
                    if (arm_rise) begin
                        state_q      <= S_HDR;
                        busy_q       <= 1'b1;
                        fifo_wr_en_q <= 1'b1;
                        fifo_din_q   <= make_header(frame_cnt_q, bus.num_row);
                    end
                end
                S_HDR: begin
                    state_q      <= degenerate ? S_DONE : S_CAP;
                    lane_cnt_q   <= '0;
                    sample_cnt_q <= '0;
                    row_cnt_q    <= '0;
                    lanes_q      <= '0;
                end
                S_CAP: begin
                    if (accept) begin
                        // A flushed word restarts from zeroed lanes so a short row's tail reads as 0.
                        lanes_q      <= emit ? '0 : lanes_d;
                        lane_cnt_q   <= emit ? 2'd0 : lane_cnt_q + 2'd1;
                        fifo_wr_en_q <= emit;
                        fifo_din_q   <= emit ? OUT_W'(lanes_d) : fifo_din_q;
                        sample_cnt_q <= last_sample ? 16'd0 : sample_cnt_q + 16'd1;
                        row_cnt_q    <= last_sample ? row_cnt_q + 10'd1 : row_cnt_q;
                        state_q      <= (last_sample && last_row) ? S_DONE : S_CAP;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_din   = fifo_din_q;
    assign bus.fifo_wr_en = fifo_wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.overflow   = overflow_q;
    assign bus.sample_err = sample_err_q;

endmodule

// File: tb/tb_adc1_capture_packer.sv
// tb_adc1_capture_packer: random and directed frames checked against a word-level model of the packer.
module tb_adc1_capture_packer;

    localparam int NEVER = 32'h7fff_ffff;

    localparam logic [63:0] T1 [5] = '{
        64'hA5C3_0000_0000_0002, 64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004,
        64'h000B_000A_0009_0008, 64'h000F_000E_000D_000C
    };
    localparam logic [63:0] T2 [3] = '{
        64'hA5C3_0001_0000_0001, 64'h0004_0003_0002_0001, 64'h0000_0000_0006_0005
    };

    typedef struct {
        logic [63:0] w;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc1_capture_packer_if bus ();

    adc1_capture_packer dut (
        .adc1_out_clk (clk),
        .rst          (rst),
        .bus          (bus)
    );

    exp_t        expq[$];
    logic [63:0] wlog[$];
    exp_t        e_cmp;
    int          cyc      = 0;
    int          nchecks  = 0;
    int          nerr     = 0;
    int          fd_cyc   = -1;
    int          ovf_from = NEVER;
    int          err_from = NEVER;
    logic [15:0] fc_model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nchecks++;
        nerr++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Word stream, frame pulse, counter and sticky flags compared every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_wr_en) begin
                wlog.push_back(bus.fifo_din);
                if (expq.size() == 0) fail_now($sformatf("unexpected_write din=%h", bus.fifo_din));
                else begin
                    e_cmp = expq.pop_front();
                    check("fifo_din", bus.fifo_din, e_cmp.w);
                    if (e_cmp.c >= 0) check("wr_cycle", 64'(cyc), 64'(e_cmp.c));
                end
            end else if (expq.size() > 0 && expq[0].c >= 0 && expq[0].c < cyc) begin
                fail_now($sformatf("missing_write want=%h at cycle %0d", expq[0].w, expq[0].c));
                void'(expq.pop_front());
            end
            if (cyc == fd_cyc) fc_model++;
            check("frame_done", 64'(bus.frame_done), 64'(cyc == fd_cyc));
            check("frame_cnt", 64'(bus.frame_cnt), 64'(fc_model));
            check("overflow", 64'(bus.overflow), 64'(cyc >= ovf_from));
            check("sample_err", 64'(bus.sample_err), 64'(cyc >= err_from));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int h);
        h = -1;
        for (int i = 0; i < 12 && h < 0; i++) begin
            @(negedge clk);
            if (bus.busy) h = cyc;
        end
        if (h < 0) fail_now("busy_timeout");
    endtask

    task automatic push_header(input int rows);
        exp_t e;
        e.w = {16'hA5C3, fc_model, 16'h0000, 6'b0, 10'(rows)};
        e.c = -1;
        expq.push_back(e);
    endtask

    // base >= 0 gives samples base, base+1, ...; base < 0 gives random samples.
    task automatic do_frame(input int rows, input int spr, input bit gaps, input int base,
                            input int full_word, input bit keep_arm, input bit rearm);
        logic [15:0] d[$];
        int          dc[$];
        int          wcs[$];
        int          h, t, k, n, j, last, full_cyc;
        bit          is_wr;
        exp_t        e;
        bus.num_row = 10'(rows);
        bus.samples_per_row = 16'(spr);
        push_header(rows);
        bus.arm = 1'b1;
        wait_busy(h);
        if (h < 0) begin
            expq.delete();
            bus.arm = 1'b0;
            return;
        end
        if (!keep_arm) bus.arm = 1'b0;
        n = rows * spr;
        t = h + 1;
        for (int i = 0; i < n; i++) begin
            if (gaps) t += $urandom_range(0, 2);
            dc.push_back(t);
            d.push_back(base >= 0 ? 16'(base + i) : 16'($urandom));
            t++;
        end
        k = 0;
        full_cyc = -1;
        for (int r = 0; r < rows; r++) begin
            for (int f = 0; f < spr; f += 4) begin
                last = r * spr + ((f + 3 < spr) ? f + 3 : spr - 1);
                e.w = '0;
                for (int i = r * spr + f; i <= last; i++) e.w |= 64'(d[i]) << (16 * (i - r * spr - f));
                e.c = dc[last] + 1;
                expq.push_back(e);
                wcs.push_back(e.c);
                if (k == full_word) full_cyc = e.c;
                k++;
            end
        end
        fd_cyc = (n == 0) ? h + 2 : dc[n-1] + 2;
        j = 0;
        tick();
        while (cyc <= fd_cyc) begin
            bus.adc_dat_valid = (j < n) && (dc[j] == cyc);
            bus.adc_data = bus.adc_dat_valid ? d[j] : 16'($urandom);
            is_wr = 1'b0;
            foreach (wcs[i]) if (wcs[i] == cyc) is_wr = 1'b1;
            bus.fifo_full = (cyc == full_cyc) || (!is_wr && $urandom_range(0, 3) == 0);
            if (cyc == full_cyc && ovf_from == NEVER) ovf_from = cyc + 1;
            bus.arm = keep_arm || (rearm && cyc >= h + 2 && cyc <= h + 4);
            if (bus.adc_dat_valid) j++;
            tick();
        end
        bus.adc_dat_valid = 1'b0;
        bus.fifo_full = 1'b0;
        check("busy_after_frame", 64'(bus.busy), 64'(0));
        if (!keep_arm) begin
            bus.arm = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_din"}, bus.fifo_din, 64'h0);
        check({tag, "_wr_en"}, 64'(bus.fifo_wr_en), 64'h0);
        check({tag, "_busy"}, 64'(bus.busy), 64'h0);
        check({tag, "_frame_done"}, 64'(bus.frame_done), 64'h0);
        check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'h0);
        check({tag, "_overflow"}, 64'(bus.overflow), 64'h0);
        check({tag, "_sample_err"}, 64'(bus.sample_err), 64'h0);
    endtask

    initial begin
        int h, rows, spr;
        rst = 1'b1;
        bus.arm = 1'b0;
        bus.num_row = '0;
        bus.samples_per_row = '0;
        bus.adc_dat_valid = 1'b0;
        bus.adc_data = '0;
        bus.fifo_full = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");
        repeat (2) tick();

        // Two rows of eight with counting data.
        wlog.delete();
        do_frame(2, 8, 1'b0, 0, -1, 1'b0, 1'b0);
        check("t1_words", 64'(wlog.size()), 64'd5);
        if (wlog.size() == 5) foreach (T1[i]) check($sformatf("t1_word%0d", i), wlog[i], T1[i]);
        check("t1_frame_cnt", 64'(bus.frame_cnt), 64'd1);

        // Six samples per row: second word is a partial with zeroed upper lanes.
        wlog.delete();
        do_frame(1, 6, 1'b0, 1, -1, 1'b0, 1'b0);
        check("t2_words", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) foreach (T2[i]) check($sformatf("t2_word%0d", i), wlog[i], T2[i]);

        // Gapped valid: same six data words as a gapless 3x8 frame.
        wlog.delete();
        do_frame(3, 8, 1'b1, 0, -1, 1'b0, 1'b0);
        check("t3_words", 64'(wlog.size()), 64'd7);
        if (wlog.size() == 7) check("t3_word6", wlog[6], 64'h0017_0016_0015_0014);

        // Random sizes and data, arm re-pulsed mid-frame on longer frames.
        for (int i = 0; i < 6; i++) begin
            rows = $urandom_range(1, 3);
            spr = $urandom_range(1, 9);
            do_frame(rows, spr, 1'b1, -1, -1, 1'b0, rows * spr >= 8);
        end
        do_frame(2, 0, 1'b0, -1, -1, 1'b0, 1'b0);
        check("no_false_overflow", 64'(bus.overflow), 64'h0);

        // FIFO full during the second data word.
        do_frame(2, 8, 1'b0, 0, 1, 1'b0, 1'b0);
        check("t4_overflow", 64'(bus.overflow), 64'h1);
        do_frame(1, 4, 1'b1, -1, -1, 1'b0, 1'b0);
        check("t4_overflow_sticky", 64'(bus.overflow), 64'h1);

        // Zero rows with arm held high across frame end.
        wlog.delete();
        do_frame(0, 8, 1'b0, -1, -1, 1'b1, 1'b0);
        repeat (12) tick();
        check("t6_words", 64'(wlog.size()), 64'd1);
        check("t6_idle_busy", 64'(bus.busy), 64'h0);
        bus.arm = 1'b0;
        repeat (4) tick();
        do_frame(1, 4, 1'b0, -1, -1, 1'b0, 1'b0);

        // Stray valid while idle, then reset after three samples of a frame.
        bus.adc_dat_valid = 1'b1;
        if (err_from == NEVER) err_from = cyc + 1;
        repeat (2) tick();
        bus.adc_dat_valid = 1'b0;
        tick();
        check("t5_sample_err", 64'(bus.sample_err), 64'h1);
        bus.num_row = 10'd1;
        bus.samples_per_row = 16'd8;
        push_header(1);
        bus.arm = 1'b1;
        wait_busy(h);
        bus.arm = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.adc_dat_valid = 1'b1;
            bus.adc_data = 16'(i + 16'h100);
            tick();
        end
        bus.adc_dat_valid = 1'b0;
        tick();
        check("t5_pending", 64'(expq.size()), 64'd0);
        rst = 1'b1;
        expq.delete();
        fd_cyc = -1;
        ovf_from = NEVER;
        err_from = NEVER;
        fc_model = '0;
        repeat (2) tick();
        rst = 1'b0;
        check_all_zero("t5_after_rst");
        repeat (3) tick();
        wlog.delete();
        do_frame(1, 4, 1'b0, 0, -1, 1'b0, 1'b0);
        check("t5_words", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) check("t5_header", wlog[0], 64'hA5C3_0000_0000_0001);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
